// File: rtl/four_state_pkg.sv
// four_state_pkg
//   Shared types and default parameters for four_state_sampler and its
//   per-bit classifier.
//   Contents:
//     DEF_W, DEF_SETTLE_CYC, DEF_TIMEOUT : parameter defaults
//     state_t                            : sampler FSM states
//     bit_class_t                        : per-bit class of a sampled bus bit
//     classify_bit()                     : maps one four-state bit to its class
package four_state_pkg;

    localparam int DEF_W          = 6;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        BIT_ZERO,
        BIT_ONE,
        BIT_X,
        BIT_Z
    } bit_class_t;

    // b ^ b is 0 for a driven 0/1 and x for an x or z input, so a known bit
    // is detected without an x constant. In a two-state world every bit is
    // known and the x/z branches are unreachable.
    function automatic bit_class_t classify_bit(input logic b);
        bit_class_t c;
        if ((b ^ b) === 1'b0) begin
            c = b ? BIT_ONE : BIT_ZERO;
        end else if (b === 1'bz) begin
            c = BIT_Z;
        end else begin
            c = BIT_X;
        end
        return c;
    endfunction

endpackage

// File: rtl/four_state_classify.sv
// four_state_classify
//   Combinational per-bit classification of a four-state bus into clean
//   two-state data plus x/z masks. Unknown bits are replaced by X_FILL.
//   Ports:
//     bus_i    [W-1:0] in  : four-state bus value
//     data_o   [W-1:0] out : two-state data, x/z bits replaced by X_FILL
//     x_mask_o [W-1:0] out : 1 where bus_i bit is x
//     z_mask_o [W-1:0] out : 1 where bus_i bit is z
module four_state_classify
    import four_state_pkg::*;
#(
    parameter int   W      = DEF_W,
    parameter logic X_FILL = 1'b0
) (
    input  logic [W-1:0] bus_i,
    output logic [W-1:0] data_o,
    output logic [W-1:0] x_mask_o,
    output logic [W-1:0] z_mask_o
);

    always_comb begin
        data_o   = '0;
        x_mask_o = '0;
        z_mask_o = '0;
        for (int i = 0; i < W; i++) begin
            case (classify_bit(bus_i[i]))
                BIT_ONE:  data_o[i] = 1'b1;
                BIT_ZERO: data_o[i] = 1'b0;
                BIT_X: begin
                    data_o[i]   = X_FILL;
                    x_mask_o[i] = 1'b1;
                end
                default: begin
                    data_o[i]   = X_FILL;
                    z_mask_o[i] = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/four_state_sampler.sv
// four_state_sampler
//   Samples a shared four-state bus on request, waits for it to settle (or
//   times out) and presents a clean two-state result with x/z masks through
//   a valid/ready handshake.
//   Optional feature: define FOUR_STATE_STATS_EN to enable the saturating
//   x_count/z_count capture statistics; otherwise both ports are tied to 0.
//   Ports:
//     clk, rst             : rising-edge clock, async active-high reset
//     bus_in      [W-1:0]  : shared four-state bus
//     sample_req           : start a transaction (accepted in IDLE only)
//     out_ready            : consumer accepts the result
//     out_valid            : result valid (HOLD state)
//     out_data    [W-1:0]  : captured data, x/z replaced by X_FILL
//     x_mask/z_mask[W-1:0] : positions of x / z bits in the capture
//     out_timeout          : capture forced by timeout
//     x_count/z_count[7:0] : captures containing x / z (saturating)
//
//   state  | meaning
//   IDLE   | waiting for sample_req, last result retained
//   SETTLE | tracking bus stability and the timeout
//   HOLD   | result presented, waiting for out_ready
module four_state_sampler
    import four_state_pkg::*;
#(
    parameter int   W          = DEF_W,
    parameter int   SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int   TIMEOUT    = DEF_TIMEOUT,
    parameter logic X_FILL     = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  wire  [W-1:0] bus_in,
    input  logic         sample_req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [W-1:0] x_mask,
    output logic [W-1:0] z_mask,
    output logic         out_timeout,
    output logic [7:0]   x_count,
    output logic [7:0]   z_count
);

    state_t         state_q, state_d;
    logic [W-1:0]   prev_q, prev_d;
    logic [3:0]     stab_q, stab_d;
    logic [7:0]     tmo_q, tmo_d;
    logic           first_q, first_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   xm_q, xm_d;
    logic [W-1:0]   zm_q, zm_d;
    logic           timeout_q, timeout_d;

    logic [W-1:0]   cls_data, cls_xm, cls_zm;

    four_state_classify #(
        .W      (W),
        .X_FILL (X_FILL)
    ) u_classify (
        .bus_i    (bus_in),
        .data_o   (cls_data),
        .x_mask_o (cls_xm),
        .z_mask_o (cls_zm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            first_q   <= 1'b0;
            data_q    <= '0;
            xm_q      <= '0;
            zm_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            stab_q    <= stab_d;
            tmo_q     <= tmo_d;
            first_q   <= first_d;
            data_q    <= data_d;
            xm_q      <= xm_d;
            zm_q      <= zm_d;
            timeout_q <= timeout_d;
        end
    end

    // The settle and timeout decisions look at the registered counters, so
    // the capture lands one edge after the count is reached. The first
    // SETTLE cycle only seeds prev and does not advance the timeout.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        stab_d    = stab_q;
        tmo_d     = tmo_q;
        first_d   = first_q;
        data_d    = data_q;
        xm_d      = xm_q;
        zm_d      = zm_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (sample_req) begin
                    state_d = SETTLE;
                    prev_d  = '0;
                    stab_d  = '0;
                    tmo_d   = '0;
                    first_d = 1'b1;
                end
            end
            SETTLE: begin
                prev_d  = bus_in;
                first_d = 1'b0;
                if (first_q) begin
                    // seed prev only
                end else if (stab_q == 4'(SETTLE_CYC)) begin
                    // settle is checked first so it wins a tie with timeout
                    state_d   = HOLD;
                    data_d    = cls_data;
                    xm_d      = cls_xm;
                    zm_d      = cls_zm;
                    timeout_d = 1'b0;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_d   = HOLD;
                    data_d    = cls_data;
                    xm_d      = cls_xm;
                    zm_d      = cls_zm;
                    timeout_d = 1'b1;
                end else begin
                    stab_d = (bus_in === prev_q) ? stab_q + 4'd1 : 4'd0;
                    tmo_d  = tmo_q + 8'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid   = (state_q == HOLD);
    assign out_data    = data_q;
    assign x_mask      = xm_q;
    assign z_mask      = zm_q;
    assign out_timeout = timeout_q;

`ifdef FOUR_STATE_STATS_EN
    logic       capture_w;
    logic [7:0] x_cnt_q, z_cnt_q;

    assign capture_w = (state_q == SETTLE) && (state_d == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt_q <= '0;
            z_cnt_q <= '0;
        end else if (capture_w) begin
            if ((|cls_xm) && (x_cnt_q != 8'hFF)) x_cnt_q <= x_cnt_q + 8'd1;
            if ((|cls_zm) && (z_cnt_q != 8'hFF)) z_cnt_q <= z_cnt_q + 8'd1;
        end
    end

    assign x_count = x_cnt_q;
    assign z_count = z_cnt_q;
`else
    assign x_count = '0;
    assign z_count = '0;
`endif

endmodule

// File: tb/tb_four_state_sampler.sv
module tb_four_state_sampler;

    localparam int W          = 6;
    localparam int SETTLE_CYC = 2;
    localparam int TIMEOUT    = 16;
`ifdef FOUR_STATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] xm;
        logic [W-1:0] zm;
        logic         tmo;
        int           lat;
    } exp_t;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic [W-1:0] bus_drv    = '0;
    logic         sample_req = 1'b0;
    logic         out_ready  = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data, x_mask, z_mask;
    logic         out_timeout;
    logic [7:0]   x_count, z_count;

    int   checks   = 0;
    int   failures = 0;
    int   exp_xc   = 0;
    int   exp_zc   = 0;
    bit   four_state;
    logic probe;
    exp_t sb[$];

    four_state_sampler #(
        .W          (W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT),
        .X_FILL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_in      (bus_drv),
        .sample_req  (sample_req),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .x_mask      (x_mask),
        .z_mask      (z_mask),
        .out_timeout (out_timeout),
        .x_count     (x_count),
        .z_count     (z_count)
    );

    always #5 clk = ~clk;

    task automatic model_stats(input exp_t e);
        if (STATS && (|e.xm) && exp_xc < 255) exp_xc++;
        if (STATS && (|e.zm) && exp_zc < 255) exp_zc++;
    endtask

    // sample_req is high across exactly one rising edge (E0)
    task automatic pulse_req();
        @(negedge clk);
        sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
    endtask

    // edges after the current one until out_valid is seen; -1 if never
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) lat = k;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, x_mask, z_mask, out_timeout, x_count, z_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%b xm=%b zm=%b t=%b xc=%0d zc=%0d want all zero",
                     out_valid, out_data, x_mask, z_mask, out_timeout, x_count, z_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_stable();
        logic [W-1:0] pats [3];
        exp_t e;
        int   lat;
        pats[0] = 6'b001011;
        pats[1] = 6'b110100;
        pats[2] = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            bus_drv = pats[i];
            sb.push_back('{pats[i], 6'd0, 6'd0, 1'b0, SETTLE_CYC + 2});
            pulse_req();
            wait_valid(lat);
            e = sb.pop_front();
            model_stats(e);
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL stable_latency[%0d]: got %0d want %0d", i, lat, e.lat);
            end
            checks++;
            if ({out_data, x_mask, z_mask, out_timeout} !== {e.data, e.xm, e.zm, e.tmo}) begin
                failures++;
                $display("FAIL stable_result[%0d]: got d=%b xm=%b zm=%b t=%b want d=%b xm=%b zm=%b t=%b",
                         i, out_data, x_mask, z_mask, out_timeout, e.data, e.xm, e.zm, e.tmo);
            end
            checks++;
            if ({x_count, z_count} !== {8'(exp_xc), 8'(exp_zc)}) begin
                failures++;
                $display("FAIL stable_counts[%0d]: got xc=%0d zc=%0d want xc=%0d zc=%0d",
                         i, x_count, z_count, exp_xc, exp_zc);
            end
            accept();
            checks++;
            if ({out_valid, out_data} !== {1'b0, e.data}) begin
                failures++;
                $display("FAIL stable_release[%0d]: got v=%b d=%b want v=0 d=%b",
                         i, out_valid, out_data, e.data);
            end
        end
    endtask

    task automatic test_undriven();
        exp_t e;
        int   lat;
        bus_drv = 6'bzzzzzz;
        sb.push_back('{6'd0, 6'd0, 6'b111111, 1'b0, SETTLE_CYC + 2});
        pulse_req();
        wait_valid(lat);
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat || {out_data, x_mask, z_mask, out_timeout} !== {e.data, e.xm, e.zm, e.tmo}) begin
            failures++;
            $display("FAIL undriven_result: got lat=%0d d=%b xm=%b zm=%b t=%b want lat=%0d d=%b xm=%b zm=%b t=%b",
                     lat, out_data, x_mask, z_mask, out_timeout, e.lat, e.data, e.xm, e.zm, e.tmo);
        end
        checks++;
        if ({x_count, z_count} !== {8'(exp_xc), 8'(exp_zc)}) begin
            failures++;
            $display("FAIL undriven_counts: got xc=%0d zc=%0d want xc=%0d zc=%0d",
                     x_count, z_count, exp_xc, exp_zc);
        end
        accept();
    endtask

    task automatic test_xz();
        exp_t e;
        int   lat;
        bus_drv = 6'b0x1z01;
        sb.push_back('{6'b001001, 6'b010000, 6'b000100, 1'b0, SETTLE_CYC + 2});
        pulse_req();
        wait_valid(lat);
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat || {out_data, x_mask, z_mask, out_timeout} !== {e.data, e.xm, e.zm, e.tmo}) begin
            failures++;
            $display("FAIL xz_result: got lat=%0d d=%b xm=%b zm=%b t=%b want lat=%0d d=%b xm=%b zm=%b t=%b",
                     lat, out_data, x_mask, z_mask, out_timeout, e.lat, e.data, e.xm, e.zm, e.tmo);
        end
        checks++;
        if ({x_count, z_count} !== {8'(exp_xc), 8'(exp_zc)}) begin
            failures++;
            $display("FAIL xz_counts: got xc=%0d zc=%0d want xc=%0d zc=%0d",
                     x_count, z_count, exp_xc, exp_zc);
        end
        accept();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   lat;
        int   held_bad;
        // bus alternates 6/5 every edge, so edge E17 samples 5
        bus_drv = 6'd6;
        sb.push_back('{6'd5, 6'd0, 6'd0, 1'b1, TIMEOUT + 1});
        pulse_req();
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            bus_drv = (bus_drv == 6'd6) ? 6'd5 : 6'd6;
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) lat = k;
        end
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL timeout_latency: got %0d want %0d", lat, e.lat);
        end
        checks++;
        if ({out_data, x_mask, z_mask, out_timeout} !== {e.data, e.xm, e.zm, e.tmo}) begin
            failures++;
            $display("FAIL timeout_result: got d=%b xm=%b zm=%b t=%b want d=%b xm=%b zm=%b t=%b",
                     out_data, x_mask, z_mask, out_timeout, e.data, e.xm, e.zm, e.tmo);
        end
        held_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_drv = (bus_drv == 6'd6) ? 6'd5 : 6'd6;
            @(posedge clk);
            #1;
            if ({out_valid, out_data, x_mask, z_mask, out_timeout} !== {1'b1, e.data, e.xm, e.zm, e.tmo})
                held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL hold_stable: %0d unstable cycles of 10, want 0", held_bad);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   seen;
        bus_drv = 6'b010101;
        sb.push_back('{6'b010101, 6'd0, 6'd0, 1'b0, SETTLE_CYC + 2});
        pulse_req();
        wait_valid(lat);
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat || {out_data, out_timeout} !== {e.data, e.tmo}) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d d=%b t=%b want lat=%0d d=%b t=%b",
                     lat, out_data, out_timeout, e.lat, e.data, e.tmo);
        end
        @(negedge clk);
        out_ready  = 1'b1;
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        sample_req = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release: out_valid got %b want 0", out_valid);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL b2b_dropped_req: out_valid got %0d want 0", seen);
        end
        // one-cycle glitch: A at E0/E1, B from E2 on -> capture B at E5
        bus_drv = 6'b100110;
        sb.push_back('{6'b011001, 6'd0, 6'd0, 1'b0, SETTLE_CYC + 3});
        pulse_req();
        @(posedge clk);
        @(negedge clk);
        bus_drv = 6'b011001;
        wait_valid(lat);
        if (lat > 0) lat = lat + 1;
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat || {out_data, out_timeout} !== {e.data, e.tmo}) begin
            failures++;
            $display("FAIL glitch_restart: got lat=%0d d=%b t=%b want lat=%0d d=%b t=%b",
                     lat, out_data, out_timeout, e.lat, e.data, e.tmo);
        end
        accept();
    endtask

    task automatic test_abort();
        exp_t e;
        int   lat;
        int   seen;
        bus_drv = 6'b101010;
        pulse_req();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        exp_xc = 0;
        exp_zc = 0;
        #1;
        checks++;
        if ({out_valid, out_data, x_mask, z_mask, out_timeout, x_count, z_count} !== '0) begin
            failures++;
            $display("FAIL abort_async_clear: got v=%b d=%b xm=%b zm=%b t=%b xc=%0d zc=%0d want all zero",
                     out_valid, out_data, x_mask, z_mask, out_timeout, x_count, z_count);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_result: out_valid got %0d want 0", seen);
        end
        sb.push_back('{6'b101010, 6'd0, 6'd0, 1'b0, SETTLE_CYC + 2});
        pulse_req();
        wait_valid(lat);
        e = sb.pop_front();
        model_stats(e);
        checks++;
        if (lat !== e.lat || {out_data, x_mask, z_mask, out_timeout} !== {e.data, e.xm, e.zm, e.tmo}) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d d=%b t=%b want lat=%0d d=%b t=%b",
                     lat, out_data, out_timeout, e.lat, e.data, e.tmo);
        end
        accept();
    endtask

    task automatic test_stats();
        exp_t e;
        int   lat;
        int   bad_lat;
        bad_lat = 0;
        bus_drv = 6'bxxxxxx;
        for (int i = 0; i < 300; i++) begin
            sb.push_back('{6'd0, 6'b111111, 6'd0, 1'b0, SETTLE_CYC + 2});
            pulse_req();
            wait_valid(lat);
            e = sb.pop_front();
            model_stats(e);
            if (lat !== e.lat) bad_lat++;
            accept();
        end
        checks++;
        if (bad_lat != 0) begin
            failures++;
            $display("FAIL stats_latency: %0d captures with wrong latency, want 0", bad_lat);
        end
        checks++;
        if ({x_count, z_count} !== {8'(exp_xc), 8'(exp_zc)}) begin
            failures++;
            $display("FAIL stats_counts: got xc=%0d zc=%0d want xc=%0d zc=%0d",
                     x_count, z_count, exp_xc, exp_zc);
        end
        checks++;
        if (x_count !== 8'd255) begin
            failures++;
            $display("FAIL stats_saturate: x_count got %0d want 255", x_count);
        end
    endtask

    initial begin
        probe      = 1'bx;
        four_state = (probe !== 1'b0) && (probe !== 1'b1);
        test_reset();
        test_stable();
        if (four_state) begin
            test_undriven();
            test_xz();
        end
        test_timeout();
        test_back_to_back();
        test_abort();
`ifdef FOUR_STATE_STATS_EN
        if (four_state) test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
